// File: rtl/dcache_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dcache_sram_arbiter
// Brief  : Grants the shared D-cache tag/data SRAM port to one of NR_PORTS
//          controllers. Port 0 (snoop) has fixed priority and the rest rotate.
//          The owner keeps the port while it requests, up to MAX_HOLD cycles.
//          Optional counters are enabled with DCACHE_SRAM_ARB_PERF_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module dcache_sram_arbiter #(
    parameter int NR_PORTS = 4,
    parameter int WAYS     = 8,
    parameter int INDEX_W  = 12,
    parameter int TAG_W    = 44,
    parameter int MAX_HOLD = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NR_PORTS*WAYS-1:0]      req_i,
    input  logic [NR_PORTS-1:0]           we_i,
    input  logic [NR_PORTS*INDEX_W-1:0]   addr_i,
    input  logic [NR_PORTS*TAG_W-1:0]     tag_i,
    output logic [NR_PORTS-1:0]           gnt_o,
    output logic [NR_PORTS-1:0]           updating_o,
    output logic [WAYS-1:0]               sram_req_o,
    output logic                          sram_we_o,
    output logic [INDEX_W-1:0]            sram_addr_o,
    output logic [TAG_W-1:0]              sram_tag_o,
    output logic [$clog2(NR_PORTS)-1:0]   sel_o,
    output logic                          busy_o
`ifdef DCACHE_SRAM_ARB_PERF_EN
    ,
    output logic [NR_PORTS*32-1:0]        perf_conflict_o,
    output logic [31:0]                   perf_forced_o
`endif
);

    localparam int SEL_W  = $clog2(NR_PORTS);
    localparam int HOLD_W = $clog2(MAX_HOLD);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]          state, state_nxt;
    logic [SEL_W-1:0]    owner, owner_nxt;
    logic [SEL_W-1:0]    rr_ptr, rr_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [SEL_W-1:0]    winner;
    logic [SEL_W-1:0]    gnt_idx;
    logic [NR_PORTS-1:0] port_req;
    logic                any_req;
    logic                found;
    logic                hold_last;
    logic                grant_act;

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_port_req
        assign port_req[p] = |req_i[p*WAYS +: WAYS];
    end

    assign any_req   = |port_req;
    assign hold_last = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    // Snoop port first; otherwise the first requester at or after rr_ptr,
    // then wrap around to the ports below it.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        if (port_req[0]) begin
            found = 1'b1;
        end else begin
            for (int i = 1; i < NR_PORTS; i++) begin
                if (!found && port_req[i] && (SEL_W'(i) >= rr_ptr)) begin
                    winner = SEL_W'(i);
                    found  = 1'b1;
                end
            end
            for (int i = 1; i < NR_PORTS; i++) begin
                if (!found && port_req[i]) begin
                    winner = SEL_W'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= SEL_W'(1);
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        hold_nxt  = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_OWNED;
                    owner_nxt = winner;
                    hold_nxt  = '0;
                end
            end
            default: begin
                if (hold_last || !port_req[owner]) begin
                    state_nxt = ST_IDLE;
                    hold_nxt  = '0;
                    if (owner != '0) begin
                        rr_nxt = (owner == SEL_W'(NR_PORTS - 1)) ? SEL_W'(1)
                                                                 : owner + SEL_W'(1);
                    end
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
        endcase
    end

    // Outputs are forced quiet while reset is asserted so a held request
    // cannot be granted during the reset pulse.
    always_comb begin
        grant_act = 1'b0;
        gnt_idx   = owner;
        if (!rst_i) begin
            if (state == ST_IDLE) begin
                grant_act = any_req;
                if (any_req) begin
                    gnt_idx = winner;
                end
            end else begin
                grant_act = port_req[owner] && !hold_last;
            end
        end
        gnt_o       = '0;
        sram_req_o  = '0;
        sram_we_o   = 1'b0;
        sram_addr_o = '0;
        sram_tag_o  = '0;
        if (grant_act) begin
            gnt_o[gnt_idx] = 1'b1;
            sram_req_o     = req_i[gnt_idx*WAYS +: WAYS];
            sram_we_o      = we_i[gnt_idx];
            sram_addr_o    = addr_i[gnt_idx*INDEX_W +: INDEX_W];
            sram_tag_o     = tag_i[gnt_idx*TAG_W +: TAG_W];
        end
        sel_o      = gnt_idx;
        busy_o     = (state == ST_OWNED);
        updating_o = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            updating_o[p] = busy_o && sram_we_o && (sel_o != SEL_W'(p));
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));

`ifdef DCACHE_SRAM_ARB_PERF_EN
    logic        forced_rel;
    logic [31:0] forced_cnt;

    assign forced_rel = (state == ST_OWNED) && hold_last && port_req[owner];

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_perf_conflict
        logic [31:0] conflict_cnt;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                conflict_cnt <= '0;
            end else if (port_req[p] && !gnt_o[p] && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
        assign perf_conflict_o[p*32 +: 32] = conflict_cnt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            forced_cnt <= '0;
        end else if (forced_rel && (forced_cnt != '1)) begin
            forced_cnt <= forced_cnt + 32'd1;
        end
    end
    assign perf_forced_o = forced_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dcache_sram_arbiter
// Brief  : Directed scenarios plus randomized traffic against a tenure model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_dcache_sram_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 12;
    localparam int TW = 44;
    localparam int MH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*W-1:0]  req;
    logic [N-1:0]    we;
    logic [N*IW-1:0] addr;
    logic [N*TW-1:0] tag;
    logic [N-1:0]    gnt, upd;
    logic [W-1:0]    s_req;
    logic            s_we;
    logic [IW-1:0]   s_addr;
    logic [TW-1:0]   s_tag;
    logic [1:0]      sel;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    dcache_sram_arbiter #(.NR_PORTS(N), .WAYS(W), .INDEX_W(IW), .TAG_W(TW), .MAX_HOLD(MH)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .tag_i(tag),
        .gnt_o(gnt), .updating_o(upd), .sram_req_o(s_req), .sram_we_o(s_we),
        .sram_addr_o(s_addr), .sram_tag_o(s_tag), .sel_o(sel), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req = '0; we = '0; addr = '0; tag = '0;
    endtask

    task automatic set_port(input int p, input logic [W-1:0] ways, input logic w,
                            input logic [IW-1:0] a, input logic [TW-1:0] t);
        req[p*W +: W]   = ways;
        we[p]           = w;
        addr[p*IW +: IW] = a;
        tag[p*TW +: TW] = t;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr();
        set_port(1, 8'h03, 1'b1, 12'h123, 44'h1);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0 || s_addr !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs gnt=%b busy=%b sel=%0d addr=%h required 0", gnt, busy, sel, s_addr);
        end
        tick();
        clr();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || upd !== 4'b0000 || s_req !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_idle gnt=%b busy=%b upd=%b sreq=%h required 0", gnt, busy, upd, s_req);
        end
        tick();
    endtask

    task automatic test_single();
        set_port(2, 8'h01, 1'b0, 12'h0A0, 44'h0_1234_5678);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (gnt !== 4'b0100 || s_addr !== 12'h0A0 || busy !== (c >= 1) || sel !== 2'd2) begin
                n_fail++;
                $display("FAIL single_c%0d gnt=%b addr=%h busy=%b sel=%0d required 0100/0a0/%0d/2",
                         c, gnt, s_addr, busy, sel, (c >= 1));
            end
            tick();
        end
        clr();
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b1 || sel !== 2'd2) begin
            n_fail++;
            $display("FAIL single_release gnt=%b busy=%b sel=%0d required 0000/1/2", gnt, busy, sel);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || sel !== 2'd2) begin
            n_fail++;
            $display("FAIL single_idle busy=%b gnt=%b sel=%0d required 0/0000/2", busy, gnt, sel);
        end
        tick();
    endtask

    task automatic test_snoop_priority();
        set_port(0, 8'h80, 1'b0, 12'h011, 44'h0);
        set_port(1, 8'h02, 1'b0, 12'h022, 44'h0);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001 || s_addr !== 12'h011) begin
            n_fail++;
            $display("FAIL snoop_first gnt=%b addr=%h required 0001/011", gnt, s_addr);
        end
        tick();
        tick();
        set_port(0, 8'h00, 1'b0, 12'h000, 44'h0);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL snoop_bubble gnt=%b required 0000", gnt);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010 || s_addr !== 12'h022) begin
            n_fail++;
            $display("FAIL snoop_then_p1 gnt=%b addr=%h required 0010/022", gnt, s_addr);
        end
        tick();
        clr();
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        int cnt [N];
        int drop [N];
        int order [$];
        logic [N-1:0] prev;
        int exp_order [4];
        exp_order = '{1, 2, 3, 1};
        do_reset();
        prev = '0;
        for (int p = 0; p < N; p++) begin
            cnt[p] = 0;
            drop[p] = 0;
        end
        for (int c = 0; c < 14; c++) begin
            for (int p = 1; p < N; p++) begin
                set_port(p, (drop[p] != 0) ? 8'h00 : 8'h10, 1'b0, IW'(p), TW'(p));
                drop[p] = 0;
            end
            @(negedge clk);
            if (gnt != '0 && prev == '0) begin
                for (int p = 0; p < N; p++) if (gnt[p]) order.push_back(p);
            end
            prev = gnt;
            for (int p = 1; p < N; p++) begin
                if (gnt[p]) begin
                    cnt[p]++;
                    if (cnt[p] == 2) begin
                        cnt[p] = 0;
                        drop[p] = 1;
                    end
                end
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (order.size() <= k) begin
                n_fail++;
                $display("FAIL rr_order_%0d no grant recorded, required port %0d", k, exp_order[k]);
            end else if (order[k] != exp_order[k]) begin
                n_fail++;
                $display("FAIL rr_order_%0d got port %0d required port %0d", k, order[k], exp_order[k]);
            end
        end
        clr();
        tick();
        tick();
    endtask

    task automatic test_forced_release();
        int cnt3;
        cnt3 = 0;
        do_reset();
        set_port(3, 8'h01, 1'b0, 12'h333, 44'h3);
        for (int c = 0; c < 18; c++) begin
            if (c == 1) set_port(1, 8'h01, 1'b0, 12'h111, 44'h1);
            @(negedge clk);
            if (c < 16 && gnt === 4'b1000) cnt3++;
            if (c == 16) begin
                n_checks++;
                if (gnt !== 4'b0000 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL forced_gap gnt=%b busy=%b required 0000/1", gnt, busy);
                end
            end
            if (c == 17) begin
                n_checks++;
                if (gnt !== 4'b0010 || s_addr !== 12'h111) begin
                    n_fail++;
                    $display("FAIL forced_next gnt=%b addr=%h required 0010/111", gnt, s_addr);
                end
            end
            tick();
        end
        n_checks++;
        if (cnt3 != 16) begin
            n_fail++;
            $display("FAIL forced_hold_len got %0d cycles required 16", cnt3);
        end
        clr();
        tick();
        tick();
    endtask

    task automatic test_updating();
        set_port(1, 8'h04, 1'b1, 12'h0F0, 44'h5);
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010 || upd !== 4'b0000) begin
            n_fail++;
            $display("FAIL upd_idle gnt=%b upd=%b required 0010/0000", gnt, upd);
        end
        tick();
        set_port(0, 8'h01, 1'b0, 12'h001, 44'h0);
        set_port(2, 8'h01, 1'b0, 12'h002, 44'h0);
        @(negedge clk);
        n_checks++;
        if (upd !== 4'b1101 || gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL upd_write upd=%b gnt=%b required 1101/0010", upd, gnt);
        end
        tick();
        we[1] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (upd !== 4'b0000) begin
            n_fail++;
            $display("FAIL upd_read upd=%b required 0000", upd);
        end
        tick();
        clr();
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        set_port(2, 8'h01, 1'b0, 12'h222, 44'h2);
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst gnt=%b busy=%b required 0000/0", gnt, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0100 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_regrant gnt=%b busy=%b required 0100/0", gnt, busy);
        end
        tick();
        clr();
        tick();
        tick();
    endtask

    // Model tracks tenures: an owner receives at most MH grant cycles, then the
    // arbiter spends one cycle releasing before the next arbitration.
    task automatic test_random();
        int m_owner, m_cnt, m_rr, m_last, g, p2;
        int rem [N];
        bit cool [N];
        logic [N-1:0] preq, e_gnt, e_upd;
        logic [W+IW+TW:0] e_bus, a_bus;
        logic e_busy;
        int e_sel;
        do_reset();
        m_owner = -1; m_cnt = 0; m_rr = 1; m_last = 0;
        for (int p = 0; p < N; p++) begin
            rem[p] = 0;
            cool[p] = 1'b0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int p = 0; p < N; p++) begin
                if (cool[p]) cool[p] = 1'b0;
                else if (rem[p] == 0 && $urandom_range(0, (p == 0) ? 9 : 3) == 0)
                    rem[p] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 24))
                                                         : int'($urandom_range(1, 5));
                set_port(p, (rem[p] > 0) ? W'($urandom_range(1, 255)) : '0, 1'($urandom),
                         IW'($urandom), {12'($urandom), 32'($urandom)});
            end
            @(negedge clk);
            for (int p = 0; p < N; p++) preq[p] = |req[p*W +: W];
            g = -1;
            e_busy = (m_owner >= 0);
            if (m_owner < 0) begin
                if (preq[0]) g = 0;
                else for (int k = 0; k < N - 1; k++) begin
                    p2 = ((m_rr - 1 + k) % (N - 1)) + 1;
                    if (g < 0 && preq[p2]) g = p2;
                end
                e_sel = (g >= 0) ? g : m_last;
            end else begin
                e_sel = m_owner;
                if (preq[m_owner] && m_cnt < MH) g = m_owner;
            end
            e_gnt = '0;
            e_bus = '0;
            if (g >= 0) begin
                e_gnt[g] = 1'b1;
                e_bus = {req[g*W +: W], we[g], addr[g*IW +: IW], tag[g*TW +: TW]};
            end
            for (int p = 0; p < N; p++) e_upd[p] = e_busy && e_bus[IW+TW] && (e_sel != p);
            a_bus = {s_req, s_we, s_addr, s_tag};
            n_checks++;
            if (gnt !== e_gnt) begin
                n_fail++;
                $display("FAIL rand_gnt cyc=%0d got=%b required=%b", cyc, gnt, e_gnt);
            end
            n_checks++;
            if (busy !== e_busy) begin
                n_fail++;
                $display("FAIL rand_busy cyc=%0d got=%b required=%b", cyc, busy, e_busy);
            end
            n_checks++;
            if (sel !== 2'(e_sel)) begin
                n_fail++;
                $display("FAIL rand_sel cyc=%0d got=%0d required=%0d", cyc, sel, e_sel);
            end
            n_checks++;
            if (a_bus !== e_bus) begin
                n_fail++;
                $display("FAIL rand_sram cyc=%0d got=%h required=%h", cyc, a_bus, e_bus);
            end
            n_checks++;
            if (upd !== e_upd) begin
                n_fail++;
                $display("FAIL rand_upd cyc=%0d got=%b required=%b", cyc, upd, e_upd);
            end
            if (m_owner < 0) begin
                if (g >= 0) begin
                    m_owner = g;
                    m_cnt = 1;
                    m_last = g;
                end
            end else if (g >= 0) begin
                m_cnt++;
            end else begin
                if (m_owner != 0) m_rr = (m_owner % (N - 1)) + 1;
                m_owner = -1;
            end
            if (g >= 0 && rem[g] > 0) begin
                rem[g]--;
                if (rem[g] == 0) cool[g] = 1'b1;
            end
            tick();
        end
        clr();
        tick();
        tick();
    endtask

    initial begin
        clr();
        test_reset();
        test_single();
        test_snoop_priority();
        test_round_robin();
        test_forced_release();
        test_updating();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
